vga_timing: RTL and testbench

Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock produced by the clock divider. It runs horizontal and vertical counters and drives registered hsync/vsync, an active-video flag, the current pixel coordinates and frame/line marker pulses. It sits between the pixel-clock divider and the pixel/colour generator, which uses `pixel_x`, `pixel_y` and `video_on` to address its frame content.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_counter.sv | 43 ++++
 rtl/vga_timing.sv | 110 +++++++++++
 tb/tb_vga_timing.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the raster generator and colour logic.
package vga_pkg;

    // Coordinate width and the largest total the counters can represent
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned MAX_TOTAL = 1 << COORD_W;

    // 640x480 @ 60 Hz default timing (pixels / lines)
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Asserted sync level: 0 = active-low
    localparam bit DEF_SYNC_POL = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

    // One raster point worth of outputs, all describing the same (h,v)
    typedef struct packed {
        logic   hsync;
        logic   vsync;
        logic   video_on;
        coord_t pixel_x;
        coord_t pixel_y;
        logic   frame_start;
        logic   line_end;
    } vga_out_t;

    // Map a logical "sync asserted" flag to the pin level for a polarity
    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Enabled wrap counter: counts 0..MAX, wrap flag is registered and high while count == MAX.
module vga_counter
    import vga_pkg::*;
#(
    parameter int unsigned WIDTH = COORD_W,
    parameter int unsigned MAX   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;

    // Next count: advance when enabled, return to zero after the last value
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Count and terminal-count flag update together so wrap always matches count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= (LAST == '0);
        end else begin
            count_q <= count_d;
            wrap_q  <= (count_d == LAST);
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: h/v counters plus a registered decode of sync, blanking and markers.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = DEF_SYNC_POL
) (
    input  logic               clk_25MHz,
    input  logic               rst,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start,
    output logic               line_end
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode boundaries as coordinate-width constants (sync ranges are inclusive)
    localparam coord_t H_ACT_END  = coord_t'(H_ACTIVE);
    localparam coord_t HS_FIRST   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST    = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t V_ACT_END  = coord_t'(V_ACTIVE);
    localparam coord_t VS_FIRST   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST    = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Totals beyond the counter range cannot be represented
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_totals
        $error("vga_timing: H_TOTAL/V_TOTAL exceed the coordinate counter range");
    end

    coord_t   h_cnt;
    coord_t   v_cnt;
    logic     h_wrap;
    logic     v_wrap_unused;
    vga_out_t out_d;
    vga_out_t out_q;

    vga_counter #(
        .WIDTH (COORD_W),
        .MAX   (H_TOTAL - 1)
    ) u_h_counter (
        .clk   (clk_25MHz),
        .rst   (rst),
        .en    (1'b1),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    // Line counter steps on the cycle the pixel counter is at its last value
    vga_counter #(
        .WIDTH (COORD_W),
        .MAX   (V_TOTAL - 1)
    ) u_v_counter (
        .clk   (clk_25MHz),
        .rst   (rst),
        .en    (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap_unused)
    );

    // Decode the current counter point into the full output set
    always_comb begin
        out_d             = '0;
        out_d.hsync       = sync_level((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST), SYNC_POL);
        out_d.vsync       = sync_level((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST), SYNC_POL);
        out_d.video_on    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        out_d.pixel_x     = h_cnt;
        out_d.pixel_y     = v_cnt;
        out_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
        // h_wrap is high exactly while h_cnt == H_TOTAL-1
        out_d.line_end    = h_wrap;
    end

    // Register all outputs together so they stay aligned to one raster point
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            out_q <= '{
                hsync:       ~SYNC_POL,
                vsync:       ~SYNC_POL,
                video_on:    1'b0,
                pixel_x:     '0,
                pixel_y:     '0,
                frame_start: 1'b0,
                line_end:    1'b0
            };
        end else begin
            out_q <= out_d;
        end
    end

    assign hsync       = out_q.hsync;
    assign vsync       = out_q.vsync;
    assign video_on    = out_q.video_on;
    assign pixel_x     = out_q.pixel_x;
    assign pixel_y     = out_q.pixel_y;
    assign frame_start = out_q.frame_start;
    assign line_end    = out_q.line_end;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default 640x480 instance plus a shrunken instance for whole-frame checks.
module tb_vga_timing;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       le;
    } obs_t;

    typedef struct {
        int ha, hfp, hsy, hbp, va, vfp, vsy, vbp;
        bit pol;
    } cfg_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       d_hsync, d_vsync, d_video_on, d_frame_start, d_line_end;
    logic [9:0] d_pixel_x, d_pixel_y;
    logic       s_hsync, s_vsync, s_video_on, s_frame_start, s_line_end;
    logic [9:0] s_pixel_x, s_pixel_y;

    vga_timing dut_def (
        .clk_25MHz   (clk),
        .rst         (rst),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .video_on    (d_video_on),
        .pixel_x     (d_pixel_x),
        .pixel_y     (d_pixel_y),
        .frame_start (d_frame_start),
        .line_end    (d_line_end)
    );

    vga_timing #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b1)
    ) dut_small (
        .clk_25MHz   (clk),
        .rst         (rst),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .video_on    (s_video_on),
        .pixel_x     (s_pixel_x),
        .pixel_y     (s_pixel_y),
        .frame_start (s_frame_start),
        .line_end    (s_line_end)
    );

    obs_t obs_def, obs_small, exp_def, exp_small;
    assign obs_def   = {d_hsync, d_vsync, d_video_on, d_pixel_x, d_pixel_y, d_frame_start, d_line_end};
    assign obs_small = {s_hsync, s_vsync, s_video_on, s_pixel_x, s_pixel_y, s_frame_start, s_line_end};

    cfg_t cfg_def, cfg_small;
    int   checks;
    int   failures;
    int   edges;   // clock edges seen with reset released

    // Output k edges after release shows raster point k-1, numbered row-major from (0,0)
    function automatic obs_t model(input cfg_t c, input int n);
        obs_t e;
        int   ht, vt, pt, h, v;
        ht = c.ha + c.hfp + c.hsy + c.hbp;
        vt = c.va + c.vfp + c.vsy + c.vbp;
        e  = '0;
        if (n == 0) begin
            e.hs = ~c.pol;
            e.vs = ~c.pol;
            return e;
        end
        pt    = n - 1;
        h     = pt % ht;
        v     = (pt / ht) % vt;
        e.hs  = ((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsy)) ? c.pol : ~c.pol;
        e.vs  = ((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsy)) ? c.pol : ~c.pol;
        e.von = (h < c.ha) && (v < c.va);
        e.x   = h[9:0];
        e.y   = v[9:0];
        e.fs  = (h == 0) && (v == 0);
        e.le  = (h == ht - 1);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) edges++;
        exp_def   = model(cfg_def, edges);
        exp_small = model(cfg_small, edges);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst   = 1'b0;
        edges = 0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        edges = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs_def !== exp_def || d_hsync !== 1'b1 || d_vsync !== 1'b1) begin
                failures++;
                $display("FAIL reset_def cyc=%0d got=%h exp=%h", i, obs_def, exp_def);
            end
            checks++;
            if (obs_small !== exp_small) begin
                failures++;
                $display("FAIL reset_small cyc=%0d got=%h exp=%h", i, obs_small, exp_small);
            end
        end
    endtask

    task automatic test_first_line();
        int run   = 0;
        bit ended = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 800; i++) begin
            tick();
            checks++;
            if (obs_def !== exp_def) begin
                failures++;
                $display("FAIL line0_def edges=%0d got=%h exp=%h", edges, obs_def, exp_def);
            end
            checks++;
            if (obs_small !== exp_small) begin
                failures++;
                $display("FAIL line0_small edges=%0d got=%h exp=%h", edges, obs_small, exp_small);
            end
            if (i == 0) begin
                checks++;
                if (d_pixel_x !== 10'd0 || d_pixel_y !== 10'd0 || d_video_on !== 1'b1
                    || d_frame_start !== 1'b1) begin
                    failures++;
                    $display("FAIL first_out got x=%0d y=%0d von=%b fs=%b exp 0 0 1 1",
                             d_pixel_x, d_pixel_y, d_video_on, d_frame_start);
                end
            end
            if (!ended) begin
                if (d_video_on === 1'b1) run++;
                else begin
                    ended = 1'b1;
                    checks++;
                    if (run != 640 || d_pixel_x !== 10'd640) begin
                        failures++;
                        $display("FAIL video_run got run=%0d x=%0d exp 640 640", run, d_pixel_x);
                    end
                end
            end
        end
    endtask

    task automatic test_three_lines();
        int   hs_low = 0, le_cnt = 0, prev_fall = -1;
        logic prev_hs;
        prev_hs = d_hsync;
        for (int i = 0; i < 2400; i++) begin
            tick();
            checks++;
            if (obs_def !== exp_def) begin
                failures++;
                $display("FAIL lines_def edges=%0d got=%h exp=%h", edges, obs_def, exp_def);
            end
            if (d_hsync === 1'b0) begin
                hs_low++;
                checks++;
                if (d_pixel_x < 10'd656 || d_pixel_x > 10'd751) begin
                    failures++;
                    $display("FAIL hsync_range got x=%0d exp 656..751", d_pixel_x);
                end
            end
            if (d_line_end === 1'b1) begin
                le_cnt++;
                checks++;
                if (d_pixel_x !== 10'd799) begin
                    failures++;
                    $display("FAIL line_end_pos got x=%0d exp 799", d_pixel_x);
                end
            end
            if (prev_hs === 1'b1 && d_hsync === 1'b0) begin
                if (prev_fall >= 0) begin
                    checks++;
                    if (edges - prev_fall != 800) begin
                        failures++;
                        $display("FAIL hsync_period got %0d exp 800", edges - prev_fall);
                    end
                end
                prev_fall = edges;
            end
            prev_hs = d_hsync;
        end
        checks++;
        if (hs_low != 288 || le_cnt != 3) begin
            failures++;
            $display("FAIL line_totals got hs_low=%0d le=%0d exp 288 3", hs_low, le_cnt);
        end
    endtask

    task automatic test_small_frames();
        int         last_fs = -1, von_cnt = 0, vs_cnt = 0, frames = 0;
        logic [9:0] px = 10'd0, py = 10'd0;
        apply_reset(2);
        for (int i = 0; i < 2 * 608 + 20; i++) begin
            tick();
            checks++;
            if (obs_small !== exp_small) begin
                failures++;
                $display("FAIL frame_small edges=%0d got=%h exp=%h", edges, obs_small, exp_small);
            end
            checks++;
            if (obs_def !== exp_def) begin
                failures++;
                $display("FAIL frame_def edges=%0d got=%h exp=%h", edges, obs_def, exp_def);
            end
            checks++;
            if (s_pixel_x >= 10'd32 || s_pixel_y >= 10'd19) begin
                failures++;
                $display("FAIL bounds got x=%0d y=%0d exp <32 <19", s_pixel_x, s_pixel_y);
            end
            if (px == 10'd31 && py == 10'd18) begin
                checks++;
                if (s_pixel_x !== 10'd0 || s_pixel_y !== 10'd0 || s_frame_start !== 1'b1) begin
                    failures++;
                    $display("FAIL frame_wrap got x=%0d y=%0d fs=%b exp 0 0 1",
                             s_pixel_x, s_pixel_y, s_frame_start);
                end
            end
            if (s_frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    frames++;
                    checks++;
                    if (edges - last_fs != 608 || von_cnt != 192 || vs_cnt != 64) begin
                        failures++;
                        $display("FAIL frame_stats got per=%0d von=%0d vs=%0d exp 608 192 64",
                                 edges - last_fs, von_cnt, vs_cnt);
                    end
                end
                last_fs = edges;
                von_cnt = 0;
                vs_cnt  = 0;
            end
            if (s_video_on === 1'b1) von_cnt++;
            if (s_vsync === 1'b1) vs_cnt++;
            px = s_pixel_x;
            py = s_pixel_y;
        end
        checks++;
        if (frames != 2) begin
            failures++;
            $display("FAIL frame_count got %0d exp 2", frames);
        end
    endtask

    task automatic test_mid_frame_reset();
        apply_reset(1);
        // Small raster point (20,10) is point 10*32+20, shown 341 edges after release
        for (int i = 0; i < 341; i++) begin
            tick();
            checks++;
            if (obs_small !== exp_small || obs_def !== exp_def) begin
                failures++;
                $display("FAIL pre_reset edges=%0d got=%h/%h exp=%h/%h",
                         edges, obs_small, obs_def, exp_small, exp_def);
            end
        end
        checks++;
        if (s_pixel_x !== 10'd20 || s_pixel_y !== 10'd10) begin
            failures++;
            $display("FAIL mid_point got x=%0d y=%0d exp 20 10", s_pixel_x, s_pixel_y);
        end
        #2;
        rst   = 1'b0;
        edges = 0;
        #1;
        exp_def   = model(cfg_def, 0);
        exp_small = model(cfg_small, 0);
        checks++;
        if (obs_small !== exp_small || obs_def !== exp_def) begin
            failures++;
            $display("FAIL async_reset got=%h/%h exp=%h/%h", obs_small, obs_def, exp_small, exp_def);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_small !== exp_small || obs_def !== exp_def) begin
                failures++;
                $display("FAIL held_reset got=%h/%h exp=%h/%h",
                         obs_small, obs_def, exp_small, exp_def);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (s_pixel_x !== 10'd0 || s_pixel_y !== 10'd0 || s_frame_start !== 1'b1
            || d_frame_start !== 1'b1) begin
            failures++;
            $display("FAIL restart got x=%0d y=%0d fs=%b dfs=%b exp 0 0 1 1",
                     s_pixel_x, s_pixel_y, s_frame_start, d_frame_start);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (obs_small !== exp_small || obs_def !== exp_def) begin
                failures++;
                $display("FAIL post_reset edges=%0d got=%h/%h exp=%h/%h",
                         edges, obs_small, obs_def, exp_small, exp_def);
            end
        end
    endtask

    task automatic test_random_reset();
        for (int it = 0; it < 6; it++) begin
            int n;
            int hold;
            n    = int'($urandom_range(1, 1500));
            hold = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                tick();
                checks++;
                if (obs_small !== exp_small || obs_def !== exp_def) begin
                    failures++;
                    $display("FAIL rand_run it=%0d edges=%0d got=%h/%h exp=%h/%h",
                             it, edges, obs_small, obs_def, exp_small, exp_def);
                end
            end
            #($urandom_range(1, 3));
            rst   = 1'b0;
            edges = 0;
            #1;
            exp_def   = model(cfg_def, 0);
            exp_small = model(cfg_small, 0);
            checks++;
            if (obs_small !== exp_small || obs_def !== exp_def) begin
                failures++;
                $display("FAIL rand_async it=%0d got=%h/%h exp=%h/%h",
                         it, obs_small, obs_def, exp_small, exp_def);
            end
            repeat (hold) tick();
            checks++;
            if (obs_small !== exp_small || obs_def !== exp_def) begin
                failures++;
                $display("FAIL rand_hold it=%0d got=%h/%h exp=%h/%h",
                         it, obs_small, obs_def, exp_small, exp_def);
            end
            @(negedge clk);
            rst = 1'b1;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        edges     = 0;
        rst       = 1'b0;
        cfg_def   = '{ha: 640, hfp: 16, hsy: 96, hbp: 48, va: 480, vfp: 10, vsy: 2, vbp: 33,
                      pol: 1'b0};
        cfg_small = '{ha: 16, hfp: 4, hsy: 6, hbp: 6, va: 12, vfp: 2, vsy: 2, vbp: 3,
                      pol: 1'b1};
        test_reset();
        test_first_line();
        test_three_lines();
        test_small_frames();
        test_mid_frame_reset();
        test_random_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
